// File: rtl/mo_line_buffer_pkg.sv
// mo_line_buffer shared types and helpers.
// Transparent pixel value, FSM state type, width check.
package mo_lb_pkg;

   localparam int TRANSPARENT = 0;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } lb_state_e;

   // True when an x_w-bit counter can address h pixels.
   function automatic bit x_w_fits(input int x_w, input int h);
      return (2 ** x_w) >= h;
   endfunction

endpackage

// File: rtl/mo_line_buffer_if.sv
// mo_line_buffer pipeline-side bus: write path, read path, status.
// master = MO pipeline / GPC side, slave = line buffer.
interface mo_line_buffer_if #(
   parameter int X_W   = 9,
   parameter int PIX_W = 8
);
   logic             LINE_SWAP;
   logic             WR_LOAD;
   logic [X_W-1:0]   WR_X;
   logic             WR_FLIP;
   logic             WR_VALID;
   logic [PIX_W-1:0] WR_PIX;
   logic             RD_EN;
   logic [PIX_W-1:0] RD_PIX;
   logic             RD_VALID;
   logic             BUFSEL;
   logic             CLR_BUSY;
   logic             OVERRUN;

   modport master (
      output LINE_SWAP, WR_LOAD, WR_X, WR_FLIP,
      output WR_VALID, WR_PIX, RD_EN,
      input  RD_PIX, RD_VALID, BUFSEL,
      input  CLR_BUSY, OVERRUN
   );

   modport slave (
      input  LINE_SWAP, WR_LOAD, WR_X, WR_FLIP,
      input  WR_VALID, WR_PIX, RD_EN,
      output RD_PIX, RD_VALID, BUFSEL,
      output CLR_BUSY, OVERRUN
   );
endinterface

// File: rtl/mo_line_buffer_bank.sv
// One H_PIXELS x PIX_W line bank: conditional write, read-and-clear,
// force-clear. Ports: clk_i, clr_*, wr_*, rc_* (rc_pix_o is combinational).
module mo_lb_bank
   import mo_lb_pkg::*;
#(
   parameter int H_PIXELS = 336,
   parameter int X_W      = 9,
   parameter int PIX_W    = 8
) (
   input  logic             clk_i,
   input  logic             clr_en_i,
   input  logic [X_W-1:0]   clr_addr_i,
   input  logic             wr_en_i,
   input  logic [X_W-1:0]   wr_addr_i,
   input  logic [PIX_W-1:0] wr_pix_i,
   input  logic             rc_en_i,
   input  logic [X_W-1:0]   rc_addr_i,
   output logic [PIX_W-1:0] rc_pix_o
);

   localparam logic [PIX_W-1:0] ZERO = PIX_W'(TRANSPARENT);

   logic [PIX_W-1:0] mem_q [H_PIXELS];

   logic clr_in;
   logic wr_in;
   logic rc_in;
   logic wr_ok;

   assign clr_in = int'(clr_addr_i) < H_PIXELS;
   assign wr_in  = int'(wr_addr_i) < H_PIXELS;
   assign rc_in  = int'(rc_addr_i) < H_PIXELS;

   // First writer wins: only a transparent slot accepts an opaque pixel.
   assign wr_ok = wr_en_i && wr_in
                && (wr_pix_i != ZERO)
                && (mem_q[wr_addr_i] == ZERO);

   assign rc_pix_o = rc_in ? mem_q[rc_addr_i] : ZERO;

   always_ff @(posedge clk_i) begin
      if (clr_en_i && clr_in) begin
         mem_q[clr_addr_i] <= ZERO;
      end else if (rc_en_i && rc_in) begin
         mem_q[rc_addr_i] <= ZERO;
      end else if (wr_ok) begin
         mem_q[wr_addr_i] <= wr_pix_i;
      end
   end

endmodule

// File: rtl/mo_line_buffer.sv
// Ping-pong motion-object line buffer with clear-behind-read.
// Ports: MCKF clock, RESET sync active-high, bus (slave) write/read/status.
module mo_line_buffer
   import mo_lb_pkg::*;
#(
   parameter int H_PIXELS = 336,
   parameter int X_W      = 9,
   parameter int PIX_W    = 8
) (
   input  logic MCKF,
   input  logic RESET,
   mo_line_buffer_if.slave bus
);

   if (!x_w_fits(X_W, H_PIXELS)) begin : g_bad_xw
      $error("X_W too narrow for H_PIXELS");
   end

   localparam logic [X_W:0]     H_RX   = (X_W+1)'(H_PIXELS);
   localparam logic [X_W:0]     ONE_RX = (X_W+1)'(1);
   localparam logic [X_W-1:0]   LAST_X = X_W'(H_PIXELS - 1);
   localparam logic [X_W-1:0]   ONE_X  = X_W'(1);
   localparam logic [PIX_W-1:0] ZERO   = PIX_W'(TRANSPARENT);

   lb_state_e        state_q, state_d;
   logic [X_W-1:0]   sweep_q, sweep_d;
   logic [X_W-1:0]   wx_q, wx_d;
   logic             dir_q, dir_d;
   // One extra bit so rx can saturate at H_PIXELS.
   logic [X_W:0]     rx_q, rx_d;
   logic             bufsel_q, bufsel_d;
   logic [PIX_W-1:0] rd_pix_q, rd_pix_d;
   logic             rd_valid_q, rd_valid_d;
   logic             overrun_q, overrun_d;

   logic [1:0]       wr_en;
   logic [1:0]       rc_en;
   logic             clr_en;
   logic [X_W-1:0]   wr_addr;
   logic             wr_dir;
   logic             rd_in;
   logic             rbank;
   logic [PIX_W-1:0] rc_pix [2];

   always_comb begin
      state_d    = state_q;
      sweep_d    = sweep_q;
      wx_d       = wx_q;
      dir_d      = dir_q;
      rx_d       = rx_q;
      bufsel_d   = bufsel_q;
      rd_pix_d   = rd_pix_q;
      rd_valid_d = rd_valid_q;
      overrun_d  = overrun_q;
      wr_en      = 2'b00;
      rc_en      = 2'b00;
      clr_en     = 1'b0;
      rbank      = ~bufsel_q;
      rd_in      = rx_q < H_RX;
      // A load in the same cycle as a pixel addresses that pixel.
      wr_addr    = bus.WR_LOAD ? bus.WR_X : wx_q;
      wr_dir     = bus.WR_LOAD ? bus.WR_FLIP : dir_q;

      unique case (state_q)
         CLEAR: begin
            clr_en     = 1'b1;
            rd_pix_d   = ZERO;
            rd_valid_d = 1'b0;
            if (sweep_q == LAST_X) begin
               state_d = RUN;
               sweep_d = '0;
            end else begin
               sweep_d = sweep_q + ONE_X;
            end
         end
         RUN: begin
            if (bus.WR_LOAD) begin
               wx_d  = bus.WR_X;
               dir_d = bus.WR_FLIP;
            end
            // Step even when the bank rejects the pixel; wrap is dropped.
            if (bus.WR_VALID) begin
               wr_en[bufsel_q] = 1'b1;
               wx_d = wr_dir ? wr_addr - ONE_X : wr_addr + ONE_X;
            end
            rd_valid_d = bus.RD_EN && rd_in;
            if (bus.RD_EN) begin
               rd_pix_d     = rd_in ? rc_pix[rbank] : ZERO;
               rc_en[rbank] = rd_in;
               if (rd_in) begin
                  rx_d = rx_q + ONE_RX;
               end
            end
            // Steering above used pre-swap bufsel, so a coincident
            // read/write still lands in the old banks.
            if (bus.LINE_SWAP) begin
               bufsel_d = ~bufsel_q;
               rx_d     = '0;
               if (rd_in) begin
                  overrun_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = CLEAR;
         end
      endcase

      if (RESET) begin
         wr_en  = 2'b00;
         rc_en  = 2'b00;
         clr_en = 1'b0;
      end
   end

   always_ff @(posedge MCKF) begin
      if (RESET) begin
         state_q    <= CLEAR;
         sweep_q    <= '0;
         wx_q       <= '0;
         dir_q      <= 1'b0;
         rx_q       <= '0;
         bufsel_q   <= 1'b0;
         rd_pix_q   <= ZERO;
         rd_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sweep_q    <= sweep_d;
         wx_q       <= wx_d;
         dir_q      <= dir_d;
         rx_q       <= rx_d;
         bufsel_q   <= bufsel_d;
         rd_pix_q   <= rd_pix_d;
         rd_valid_q <= rd_valid_d;
         overrun_q  <= overrun_d;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      mo_lb_bank #(
         .H_PIXELS (H_PIXELS),
         .X_W      (X_W),
         .PIX_W    (PIX_W)
      ) u_bank (
         .clk_i      (MCKF),
         .clr_en_i   (clr_en),
         .clr_addr_i (sweep_q),
         .wr_en_i    (wr_en[b]),
         .wr_addr_i  (wr_addr),
         .wr_pix_i   (bus.WR_PIX),
         .rc_en_i    (rc_en[b]),
         .rc_addr_i  (rx_q[X_W-1:0]),
         .rc_pix_o   (rc_pix[b])
      );
   end

   assign bus.RD_PIX   = rd_pix_q;
   assign bus.RD_VALID = rd_valid_q;
   assign bus.BUFSEL   = bufsel_q;
   assign bus.CLR_BUSY = (state_q == CLEAR);
   assign bus.OVERRUN  = overrun_q;

endmodule

// File: tb/tb_mo_line_buffer.sv
// Directed bench for mo_line_buffer with a read scoreboard.
// Expected line contents are built from the stimulus, not the DUT.
module tb_mo_line_buffer;

   localparam int H = 336;

   logic clk;
   logic rst;

   mo_line_buffer_if #(.X_W(9), .PIX_W(8)) bus_if ();

   mo_line_buffer #(
      .H_PIXELS (H),
      .X_W      (9),
      .PIX_W    (8)
   ) dut (
      .MCKF  (clk),
      .RESET (rst),
      .bus   (bus_if)
   );

   typedef struct packed {
      logic       v;
      logic [7:0] p;
   } exp_t;

   exp_t       sb [$];
   logic [7:0] exp_line [H];
   int         n_cmp = 0;
   int         n_bad = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] req);
      n_cmp++;
      assert (obs === req) else begin
         n_bad++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, req);
      end
   endtask

   task automatic clr_exp();
      for (int i = 0; i < H; i++) exp_line[i] = 8'h00;
   endtask

   task automatic pop_chk(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_v"}, bus_if.RD_VALID, e.v);
         chk({tag, "_pix"}, bus_if.RD_PIX, e.p);
      end
   endtask

   task automatic readout(input string tag, input int start, input int n);
      exp_t e;
      for (int i = start; i < start + n; i++) begin
         bus_if.RD_EN = 1'b1;
         e.v = (i < H);
         e.p = (i < H) ? exp_line[i] : 8'h00;
         sb.push_back(e);
         @(negedge clk);
         pop_chk(tag);
      end
      bus_if.RD_EN = 1'b0;
   endtask

   task automatic wr(input logic ld, input logic [8:0] x,
                     input logic fl, input logic [7:0] px);
      bus_if.WR_LOAD  = ld;
      bus_if.WR_X     = x;
      bus_if.WR_FLIP  = fl;
      bus_if.WR_VALID = 1'b1;
      bus_if.WR_PIX   = px;
      @(negedge clk);
      bus_if.WR_LOAD  = 1'b0;
      bus_if.WR_VALID = 1'b0;
      bus_if.WR_PIX   = 8'h00;
   endtask

   task automatic swap();
      bus_if.LINE_SWAP = 1'b1;
      @(negedge clk);
      bus_if.LINE_SWAP = 1'b0;
   endtask

   task automatic wait_sweep(input string tag);
      int cnt = 0;
      while (bus_if.CLR_BUSY === 1'b1 && cnt < 2000) begin
         @(negedge clk);
         cnt++;
      end
      chk(tag, cnt, H);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"}, bus_if.CLR_BUSY, 1);
      chk({tag, "_bufsel"}, bus_if.BUFSEL, 0);
      chk({tag, "_rdv"}, bus_if.RD_VALID, 0);
      chk({tag, "_rdpix"}, bus_if.RD_PIX, 0);
      chk({tag, "_ovr"}, bus_if.OVERRUN, 0);
   endtask

   initial begin
      exp_t e;
      rst              = 1'b1;
      bus_if.LINE_SWAP = 1'b0;
      bus_if.WR_LOAD   = 1'b0;
      bus_if.WR_X      = '0;
      bus_if.WR_FLIP   = 1'b0;
      bus_if.WR_VALID  = 1'b0;
      bus_if.WR_PIX    = '0;
      bus_if.RD_EN     = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk_reset("rst");

      // Sweep: everything on the bus must be ignored.
      bus_if.LINE_SWAP = 1'b1;
      bus_if.RD_EN     = 1'b1;
      bus_if.WR_VALID  = 1'b1;
      bus_if.WR_PIX    = 8'hAA;
      wait_sweep("sweep_len");
      bus_if.LINE_SWAP = 1'b0;
      bus_if.RD_EN     = 1'b0;
      bus_if.WR_VALID  = 1'b0;
      bus_if.WR_PIX    = 8'h00;
      chk("sweep_bufsel", bus_if.BUFSEL, 0);
      chk("sweep_rdv", bus_if.RD_VALID, 0);
      clr_exp();
      readout("init_rd", 0, H + 2);

      // Basic ping-pong, then clear-behind-read.
      wr(1'b1, 9'd10, 1'b0, 8'd3);
      wr(1'b0, 9'd0, 1'b0, 8'd4);
      wr(1'b0, 9'd0, 1'b0, 8'd5);
      swap();
      chk("pp_bufsel", bus_if.BUFSEL, 1);
      chk("pp_ovr", bus_if.OVERRUN, 0);
      clr_exp();
      exp_line[10] = 8'd3;
      exp_line[11] = 8'd4;
      exp_line[12] = 8'd5;
      readout("pp_rd", 0, H + 2);
      swap();
      clr_exp();
      readout("pp_b", 0, H);
      swap();
      chk("pp_bufsel2", bus_if.BUFSEL, 1);
      readout("pp_clr", 0, H);

      // Overlap priority and transparent pixels (bank B).
      wr(1'b1, 9'd20, 1'b0, 8'd7);
      wr(1'b1, 9'd20, 1'b0, 8'd9);
      wr(1'b0, 9'd0, 1'b0, 8'd9);
      wr(1'b1, 9'd22, 1'b0, 8'd6);
      wr(1'b1, 9'd22, 1'b0, 8'd0);
      swap();
      clr_exp();
      exp_line[20] = 8'd7;
      exp_line[21] = 8'd9;
      exp_line[22] = 8'd6;
      readout("ovl_rd", 0, H);

      // Flip with wrap below zero (bank A).
      wr(1'b1, 9'd1, 1'b1, 8'd1);
      wr(1'b0, 9'd0, 1'b0, 8'd2);
      wr(1'b0, 9'd0, 1'b0, 8'd3);
      wr(1'b0, 9'd0, 1'b0, 8'd4);
      swap();
      clr_exp();
      exp_line[1] = 8'd1;
      exp_line[0] = 8'd2;
      readout("flip_rd", 0, H + 2);

      // Right-edge clip (bank B).
      wr(1'b1, 9'd334, 1'b0, 8'd11);
      for (int k = 12; k <= 15; k++) wr(1'b0, 9'd0, 1'b0, 8'(k));
      swap();
      chk("clip_bufsel", bus_if.BUFSEL, 0);
      clr_exp();
      exp_line[334] = 8'd11;
      exp_line[335] = 8'd12;
      readout("clip_rd", 0, H + 2);

      // Early swap with coincident read and write.
      wr(1'b1, 9'd100, 1'b0, 8'h42);
      wr(1'b0, 9'd0, 1'b0, 8'h43);
      swap();
      clr_exp();
      readout("ovr_pre", 0, 100);
      bus_if.RD_EN     = 1'b1;
      bus_if.LINE_SWAP = 1'b1;
      bus_if.WR_LOAD   = 1'b1;
      bus_if.WR_X      = 9'd0;
      bus_if.WR_FLIP   = 1'b0;
      bus_if.WR_VALID  = 1'b1;
      bus_if.WR_PIX    = 8'h55;
      e.v = 1'b1;
      e.p = 8'h42;
      sb.push_back(e);
      @(negedge clk);
      bus_if.RD_EN     = 1'b0;
      bus_if.LINE_SWAP = 1'b0;
      bus_if.WR_LOAD   = 1'b0;
      bus_if.WR_VALID  = 1'b0;
      bus_if.WR_PIX    = 8'h00;
      pop_chk("ovr_sim");
      chk("ovr_flag", bus_if.OVERRUN, 1);
      chk("ovr_bufsel", bus_if.BUFSEL, 0);
      clr_exp();
      exp_line[0] = 8'h55;
      readout("ovr_b", 0, H);
      chk("ovr_sticky1", bus_if.OVERRUN, 1);
      swap();
      clr_exp();
      exp_line[101] = 8'h43;
      readout("ovr_left", 0, H);
      chk("ovr_sticky2", bus_if.OVERRUN, 1);

      // Reset mid-line, then the sweep must have wiped bank B.
      wr(1'b1, 9'd200, 1'b0, 8'h77);
      bus_if.RD_EN = 1'b1;
      rst          = 1'b1;
      @(negedge clk);
      rst          = 1'b0;
      bus_if.RD_EN = 1'b0;
      chk_reset("rst2");
      wait_sweep("sweep2_len");
      clr_exp();
      readout("rst2_rd", 0, H);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
